// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/writeback one instruction at a time.
// 3-5 cycles per instruction with mem_ready high; memory states hold their strobes until mem_ready or timeout.
module mc_ctrl_fsm #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ir_data,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             write_pc,
    output logic [1:0]       pcsource,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             write_ir,
    output logic             regdst,
    output logic             memtoreg,
    output logic             write_reg,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [2:0]       alu_ctrl,
    output logic [3:0]       state,
    output logic             insn_done,
    output logic             halt,
    output logic [CNT_W-1:0] insn_cnt
);

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_EXR  = 4'd2,
        S_WBR  = 4'd3,
        S_MADR = 4'd4,
        S_MRD  = 4'd5,
        S_MWB  = 4'd6,
        S_MWR  = 4'd7,
        S_BR   = 4'd8,
        S_EXI  = 4'd9,
        S_WBI  = 4'd10,
        S_JMP  = 4'd11,
        S_HALT = 4'd15
    } state_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t            state_q;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_expire;
    logic              in_wait_state;
    logic [5:0]        op;
    logic [5:0]        funct;
    logic              unused_ir_bits;

    assign op             = ir_data[31:26];
    assign funct          = ir_data[5:0];
    assign unused_ir_bits = ^ir_data[25:6];

    // The last permitted wait cycle still completes if mem_ready arrives in it.
    assign wait_expire   = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST) && !mem_ready;
    assign in_wait_state = (state_q == S_IF) || (state_q == S_MRD) || (state_q == S_MWR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IF;
            wait_cnt <= '0;
            insn_cnt <= '0;
        end else begin
            state_q <= state_nxt;
            if (in_wait_state && (state_nxt == state_q))
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (insn_done)
                insn_cnt <= insn_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state_q;
        write_pc  = 1'b0;
        pcsource  = 2'b00;
        iord      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        write_ir  = 1'b0;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        write_reg = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        alu_ctrl  = ALU_AND;
        insn_done = 1'b0;

        case (state_q)
            S_IF: begin
                mem_read = 1'b1;
                alusrcb  = 2'b01;
                alu_ctrl = ALU_ADD;
                if (mem_ready) begin
                    write_ir  = 1'b1;
                    write_pc  = 1'b1;
                    state_nxt = S_ID;
                end else if (wait_expire) begin
                    state_nxt = S_HALT;
                end
            end
            S_ID: begin
                alusrcb  = 2'b11;
                alu_ctrl = ALU_ADD;
                case (op)
                    6'h00:                      state_nxt = S_EXR;
                    6'h23, 6'h2B:               state_nxt = S_MADR;
                    6'h04, 6'h05:               state_nxt = S_BR;
                    6'h08, 6'h0A, 6'h0C, 6'h0D: state_nxt = S_EXI;
                    6'h02:                      state_nxt = S_JMP;
                    default:                    state_nxt = S_HALT;
                endcase
            end
            S_EXR: begin
                alusrca   = 1'b1;
                state_nxt = S_WBR;
                case (funct)
                    6'h20:   alu_ctrl = ALU_ADD;
                    6'h22:   alu_ctrl = ALU_SUB;
                    6'h24:   alu_ctrl = ALU_AND;
                    6'h25:   alu_ctrl = ALU_OR;
                    6'h2A:   alu_ctrl = ALU_SLT;
                    default: state_nxt = S_HALT;
                endcase
            end
            S_WBR: begin
                regdst    = 1'b1;
                write_reg = 1'b1;
                insn_done = 1'b1;
                state_nxt = S_IF;
            end
            S_MADR: begin
                alusrca  = 1'b1;
                alusrcb  = 2'b10;
                alu_ctrl = ALU_ADD;
                case (op)
                    6'h23:   state_nxt = S_MRD;
                    6'h2B:   state_nxt = S_MWR;
                    default: state_nxt = S_HALT;
                endcase
            end
            S_MRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready)
                    state_nxt = S_MWB;
                else if (wait_expire)
                    state_nxt = S_HALT;
            end
            S_MWB: begin
                memtoreg  = 1'b1;
                write_reg = 1'b1;
                insn_done = 1'b1;
                state_nxt = S_IF;
            end
            S_MWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    insn_done = 1'b1;
                    state_nxt = S_IF;
                end else if (wait_expire) begin
                    state_nxt = S_HALT;
                end
            end
            S_BR: begin
                alusrca   = 1'b1;
                alu_ctrl  = ALU_SUB;
                pcsource  = 2'b01;
                write_pc  = (op == 6'h04) ? zero : !zero;
                insn_done = 1'b1;
                state_nxt = S_IF;
            end
            S_EXI: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                state_nxt = S_WBI;
                case (op)
                    6'h0A:   alu_ctrl = ALU_SLT;
                    6'h0C:   alu_ctrl = ALU_AND;
                    6'h0D:   alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            S_WBI: begin
                write_reg = 1'b1;
                insn_done = 1'b1;
                state_nxt = S_IF;
            end
            S_JMP: begin
                write_pc  = 1'b1;
                pcsource  = 2'b10;
                insn_done = 1'b1;
                state_nxt = S_IF;
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_HALT;
        endcase

        // Reset forces every strobe and select low without waiting for a clock edge.
        if (rst) begin
            write_pc  = 1'b0;
            pcsource  = 2'b00;
            iord      = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            write_ir  = 1'b0;
            regdst    = 1'b0;
            memtoreg  = 1'b0;
            write_reg = 1'b0;
            alusrca   = 1'b0;
            alusrcb   = 2'b00;
            alu_ctrl  = ALU_AND;
            insn_done = 1'b0;
        end
    end

    assign state = state_q;
    assign halt  = (state_q == S_HALT);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-instruction expected cycle sequences are generated from the instruction class
// and compared against the DUT outputs on every falling edge.
module tb_mc_ctrl_fsm;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ir_data = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        write_pc, iord, mem_read, mem_write, write_ir, regdst, memtoreg, write_reg, alusrca;
    logic [1:0]  pcsource, alusrcb;
    logic [2:0]  alu_ctrl;
    logic [3:0]  state;
    logic        insn_done, halt;
    logic [31:0] insn_cnt;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .ir_data(ir_data), .zero(zero), .mem_ready(mem_ready),
        .write_pc(write_pc), .pcsource(pcsource), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .write_ir(write_ir), .regdst(regdst), .memtoreg(memtoreg),
        .write_reg(write_reg), .alusrca(alusrca), .alusrcb(alusrcb), .alu_ctrl(alu_ctrl),
        .state(state), .insn_done(insn_done), .halt(halt), .insn_cnt(insn_cnt)
    );

    typedef struct packed {
        logic [3:0]  state;
        logic        write_pc;
        logic [1:0]  pcsource;
        logic        iord;
        logic        mem_read;
        logic        mem_write;
        logic        write_ir;
        logic        regdst;
        logic        memtoreg;
        logic        write_reg;
        logic        alusrca;
        logic [1:0]  alusrcb;
        logic [2:0]  alu_ctrl;
        logic        insn_done;
        logic        halt;
        logic [31:0] insn_cnt;
    } exp_t;

    exp_t expq[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   m_cnt = 0;
    int   lat = 0;
    int   cyc = 0;

    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        cyc++;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            a = {state, write_pc, pcsource, iord, mem_read, mem_write, write_ir, regdst, memtoreg,
                 write_reg, alusrca, alusrcb, alu_ctrl, insn_done, halt, insn_cnt};
            n_total++;
            if (a === e) n_pass++;
            else $display("FAIL cycle%0d outputs: got %h want %h", cyc, a, e);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, req);
    endtask

    function automatic exp_t mk(input logic [3:0] st);
        exp_t e;
        e = '0;
        e.state = st;
        e.insn_cnt = m_cnt;
        return e;
    endfunction

    task automatic step(input exp_t e, input logic rdy);
        mem_ready = rdy;
        expq.push_back(e);
        @(posedge clk);
        #1;
        if (e.insn_done) m_cnt++;
        lat++;
    endtask

    function automatic exp_t mem_base(input logic [3:0] st, input logic done);
        exp_t e;
        e = mk(st);
        if (st == 4'd0) begin
            e.mem_read = 1'b1; e.alusrcb = 2'b01; e.alu_ctrl = 3'b010;
            e.write_ir = done; e.write_pc = done;
        end else if (st == 4'd5) begin
            e.iord = 1'b1; e.mem_read = 1'b1;
        end else begin
            e.iord = 1'b1; e.mem_write = 1'b1; e.insn_done = done;
        end
        return e;
    endfunction

    // A memory access is abandoned after TO consecutive not-ready cycles.
    task automatic mem_phase(input logic [3:0] st, input int waits, output logic halted);
        for (int i = 0; i < waits && i < TO; i++) step(mem_base(st, 1'b0), 1'b0);
        halted = (waits >= TO);
        if (!halted) step(mem_base(st, 1'b1), 1'b1);
    endtask

    task automatic expect_halt(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e = mk(4'd15);
            e.halt = 1'b1;
            step(e, i[0]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_cnt = 0;
        step(mk(4'd0), 1'b1);
        step(mk(4'd0), 1'b0);
        rst = 1'b0;
    endtask

    task automatic run_insn(input logic [31:0] ir, input logic z, input int if_wait, input int mem_wait);
        logic [5:0] op;
        logic [5:0] fn;
        logic       h;
        exp_t       e;
        ir_data = ir; zero = z; lat = 0;
        op = ir[31:26]; fn = ir[5:0];
        mem_phase(4'd0, if_wait, h);
        if (h) begin expect_halt(3); return; end
        e = mk(4'd1); e.alusrcb = 2'b11; e.alu_ctrl = 3'b010;
        step(e, 1'b1);
        case (op)
            6'h00: begin
                e = mk(4'd2); e.alusrca = 1'b1; h = 1'b0;
                case (fn)
                    6'h20: e.alu_ctrl = 3'b010;
                    6'h22: e.alu_ctrl = 3'b110;
                    6'h24: e.alu_ctrl = 3'b000;
                    6'h25: e.alu_ctrl = 3'b001;
                    6'h2A: e.alu_ctrl = 3'b111;
                    default: h = 1'b1;
                endcase
                step(e, 1'b1);
                if (h) expect_halt(3);
                else begin
                    e = mk(4'd3); e.regdst = 1'b1; e.write_reg = 1'b1; e.insn_done = 1'b1;
                    step(e, 1'b1);
                end
            end
            6'h23, 6'h2B: begin
                e = mk(4'd4); e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alu_ctrl = 3'b010;
                step(e, 1'b1);
                mem_phase((op == 6'h23) ? 4'd5 : 4'd7, mem_wait, h);
                if (h) expect_halt(3);
                else if (op == 6'h23) begin
                    e = mk(4'd6); e.memtoreg = 1'b1; e.write_reg = 1'b1; e.insn_done = 1'b1;
                    step(e, 1'b1);
                end
            end
            6'h04, 6'h05: begin
                e = mk(4'd8); e.alusrca = 1'b1; e.alu_ctrl = 3'b110; e.pcsource = 2'b01;
                e.write_pc = (op == 6'h04) ? z : !z; e.insn_done = 1'b1;
                step(e, 1'b1);
            end
            6'h08, 6'h0A, 6'h0C, 6'h0D: begin
                e = mk(4'd9); e.alusrca = 1'b1; e.alusrcb = 2'b10;
                e.alu_ctrl = (op == 6'h08) ? 3'b010 : (op == 6'h0A) ? 3'b111 :
                             (op == 6'h0C) ? 3'b000 : 3'b001;
                step(e, 1'b1);
                e = mk(4'd10); e.write_reg = 1'b1; e.insn_done = 1'b1;
                step(e, 1'b1);
            end
            6'h02: begin
                e = mk(4'd11); e.write_pc = 1'b1; e.pcsource = 2'b10; e.insn_done = 1'b1;
                step(e, 1'b1);
            end
            default: expect_halt(3);
        endcase
    endtask

    localparam logic [31:0] I_ADD  = 32'h0022_1820;
    localparam logic [31:0] I_SUB  = 32'h0022_1822;
    localparam logic [31:0] I_AND  = 32'h0022_1824;
    localparam logic [31:0] I_OR   = 32'h0022_1825;
    localparam logic [31:0] I_SLT  = 32'h0022_182A;
    localparam logic [31:0] I_BADF = 32'h0022_1821;
    localparam logic [31:0] I_ADDI = 32'h2022_0005;
    localparam logic [31:0] I_SLTI = 32'h2822_0005;
    localparam logic [31:0] I_ANDI = 32'h3022_0005;
    localparam logic [31:0] I_ORI  = 32'h3422_0005;
    localparam logic [31:0] I_LW   = 32'h8C22_0004;
    localparam logic [31:0] I_SW   = 32'hAC22_0004;
    localparam logic [31:0] I_BEQ  = 32'h1022_0003;
    localparam logic [31:0] I_BNE  = 32'h1422_0003;
    localparam logic [31:0] I_J    = 32'h0800_0010;
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        exp_t e;
        logic h;
        @(posedge clk);
        #1;
        do_reset();
        chk("reset_state", {28'd0, state}, 32'd0);
        chk("reset_cnt", insn_cnt, 32'd0);

        run_insn(I_ADD, 1'b0, 0, 0);
        chk("add_latency", lat, 32'd4);
        chk("add_cnt", insn_cnt, 32'd1);
        run_insn(I_SUB, 1'b0, 0, 0);
        run_insn(I_AND, 1'b0, 0, 0);
        run_insn(I_OR,  1'b0, 0, 0);
        run_insn(I_SLT, 1'b0, 0, 0);
        run_insn(I_ADDI, 1'b0, 0, 0);
        chk("addi_latency", lat, 32'd4);
        run_insn(I_SLTI, 1'b0, 0, 0);
        run_insn(I_ANDI, 1'b0, 0, 0);
        run_insn(I_ORI,  1'b0, 0, 0);

        run_insn(I_LW, 1'b0, 0, 3);
        chk("lw_wait3_latency", lat, 32'd8);
        run_insn(I_LW, 1'b0, 0, 0);
        chk("lw_latency", lat, 32'd5);
        run_insn(I_SW, 1'b0, 0, 0);
        chk("sw_latency", lat, 32'd4);
        run_insn(I_SW, 1'b0, 0, 3);
        chk("sw_wait3_latency", lat, 32'd7);

        run_insn(I_BEQ, 1'b1, 0, 0);
        chk("beq_latency", lat, 32'd3);
        run_insn(I_BEQ, 1'b0, 0, 0);
        run_insn(I_BNE, 1'b1, 0, 0);
        run_insn(I_BNE, 1'b0, 0, 0);
        run_insn(I_J, 1'b0, 0, 0);
        chk("j_latency", lat, 32'd3);
        run_insn(I_ADD, 1'b0, 3, 0);
        chk("if_ready_on_last_latency", lat, 32'd7);
        chk("cnt_after_19", insn_cnt, 32'd19);

        run_insn(I_BAD, 1'b0, 0, 0);
        chk("bad_op_halt", {31'd0, halt}, 32'd1);
        chk("bad_op_state", {28'd0, state}, 32'd15);
        do_reset();
        chk("post_halt_reset_state", {28'd0, state}, 32'd0);
        chk("post_halt_reset_halt", {31'd0, halt}, 32'd0);

        run_insn(I_BADF, 1'b0, 0, 0);
        do_reset();
        run_insn(I_ADD, 1'b0, 4, 0);
        chk("if_timeout_halt", {31'd0, halt}, 32'd1);
        do_reset();
        run_insn(I_LW, 1'b0, 0, 4);
        chk("mrd_timeout_halt", {31'd0, halt}, 32'd1);
        do_reset();
        run_insn(I_ADD, 1'b0, 0, 0);
        run_insn(I_ADD, 1'b0, 0, 0);

        // Reset arriving mid-store must drop mem_write without waiting for a clock edge.
        ir_data = I_SW;
        mem_phase(4'd0, 0, h);
        e = mk(4'd1); e.alusrcb = 2'b11; e.alu_ctrl = 3'b010;
        step(e, 1'b1);
        e = mk(4'd4); e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alu_ctrl = 3'b010;
        step(e, 1'b1);
        step(mem_base(4'd7, 1'b0), 1'b0);
        mem_ready = 1'b0;
        #1;
        chk("mwr_write_before_rst", {31'd0, mem_write}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mwr_write_async_drop", {31'd0, mem_write}, 32'd0);
        chk("mwr_rst_state", {28'd0, state}, 32'd0);
        chk("mwr_rst_cnt", insn_cnt, 32'd0);
        m_cnt = 0;
        step(mk(4'd0), 1'b0);
        rst = 1'b0;
        run_insn(I_ADD, 1'b0, 0, 0);
        chk("recover_cnt", insn_cnt, 32'd1);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
